// File: rtl/riscboy_ppu_busarb_pkg.sv
// riscboy_ppu_busarb_pkg: sizing constants, lock FSM states and the
// priority-pick helper shared by the PPU bus arbiter.
package riscboy_ppu_busarb_pkg;

`include "riscboy_ppu_const.vh"

    localparam int unsigned N_REQ        = 32'd3;
    localparam int unsigned W_ADDR       = 32'd18;
    localparam int unsigned W_DATA       = 32'd16;
    localparam int unsigned MAX_INFLIGHT = 32'd4;
    localparam int unsigned W_ID         = 32'd2;
    localparam int unsigned W_LEVEL      = W_ID + 32'd1;

    typedef enum logic [0:0] {
        LOCK_IDLE = 1'b0,
        LOCK_HOLD = 1'b1
    } lock_state_t;

    // First set bit of cand, scanning upward from start with wrap-around.
    function automatic logic [W_ID-1:0] pick_first(input logic [N_REQ-1:0] cand,
                                                   input logic [W_ID-1:0]  start);
        logic [W_ID-1:0]  sel;
        logic             found;
        logic [N_REQ-1:0] rot;
        int unsigned      idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(start) + i) % N_REQ;
            rot = cand >> idx;
            if (!found && rot[0]) begin
                sel   = W_ID'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Index following id, wrapping at N_REQ.
    function automatic logic [W_ID-1:0] next_id(input logic [W_ID-1:0] id);
        return (32'(id) == (N_REQ - 32'd1)) ? '0 : (id + W_ID'(1));
    endfunction

endpackage

// File: rtl/riscboy_ppu_busarb_if.sv
// riscboy_ppu_busarb_if: requester address/data handshakes plus the
// downstream split-phase memory port. The slave modport is the arbiter's
// view; the master modport is the surrounding requesters and bus.
interface riscboy_ppu_busarb_if
    import riscboy_ppu_busarb_pkg::*;
();
    logic [N_REQ-1:0]        req_vld;
    logic [N_REQ-1:0]        req_rdy;
    logic [N_REQ*W_ADDR-1:0] req_addr;
    logic [N_REQ-1:0]        req_data_vld;
    logic [W_DATA-1:0]       req_data;
    logic                    bus_addr_vld;
    logic                    bus_addr_rdy;
    logic [W_ADDR-1:0]       bus_addr;
    logic                    bus_data_vld;
    logic [W_DATA-1:0]       bus_data;
    logic [W_LEVEL-1:0]      inflight_level;
    logic                    err_orphan_data;

    modport slave (
        input  req_vld, req_addr, bus_addr_rdy, bus_data_vld, bus_data,
        output req_rdy, req_data_vld, req_data, bus_addr_vld, bus_addr,
               inflight_level, err_orphan_data
    );

    modport master (
        output req_vld, req_addr, bus_addr_rdy, bus_data_vld, bus_data,
        input  req_rdy, req_data_vld, req_data, bus_addr_vld, bus_addr,
               inflight_level, err_orphan_data
    );
endinterface

// File: rtl/riscboy_ppu_const.vh
// Shared PPU constants: requester indices on the PPU memory port.
`ifndef RISCBOY_PPU_CONST_VH
`define RISCBOY_PPU_CONST_VH

localparam int unsigned PPU_REQ_PIXEL = 32'd0;
localparam int unsigned PPU_REQ_TILE  = 32'd1;
localparam int unsigned PPU_REQ_CMD   = 32'd2;

`endif

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and synchronous flush.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned DEPTH   = 32'd4,
    parameter int unsigned WIDTH   = 32'd8,
    parameter int unsigned W_LEVEL = $clog2(DEPTH + 32'd1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [W_LEVEL-1:0] level
);
    localparam int unsigned W_PTR = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [W_PTR-1:0]   wr_ptr_r;
    logic [W_PTR-1:0]   rd_ptr_r;
    logic [W_LEVEL-1:0] level_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
        return (p == W_PTR'(DEPTH - 32'd1)) ? '0 : (p + W_PTR'(1));
    endfunction

    assign full      = (level_r == W_LEVEL'(DEPTH));
    assign empty     = (level_r == '0);
    assign level     = level_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + W_LEVEL'(1);
                2'b01:   level_r <= level_r - W_LEVEL'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
    end
endmodule

// File: rtl/riscboy_ppu_busarb.sv
// riscboy_ppu_busarb: arbitrates PPU requesters onto the single halfword
// memory port, locks the grant across a stalled address phase, and routes
// in-order read data back to the requester that issued each fetch.
// Optional: RISCBOY_PPU_BUSARB_ROUND_ROBIN_EN selects rotating priority;
// otherwise fixed priority with the pixel AGU highest.
module riscboy_ppu_busarb
    import riscboy_ppu_busarb_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    riscboy_ppu_busarb_if.slave ppu
);
    lock_state_t        state_r, state_s;
    logic [W_ID-1:0]    lock_id_r, lock_id_s;
    logic [N_REQ-1:0]   cand_s;
    logic [W_ID-1:0]    arb_id_s;
    logic [W_ID-1:0]    gnt_id_s;
    logic               gnt_vld_s;
    logic               hold_active_s;
    logic [W_ADDR-1:0]  gnt_addr_s;
    logic               push_s;
    logic               pop_s;
    logic               q_full_s;
    logic               q_empty_s;
    logic [W_LEVEL-1:0] level_s;
    logic [W_ID-1:0]    head_id_s;
    logic               err_orphan_r;

    // Full is the pre-pop occupancy, so a same-cycle pop never frees a slot.
    assign cand_s        = ppu.req_vld & ~{N_REQ{q_full_s}};
    assign hold_active_s = (state_r == LOCK_HOLD) && |(ppu.req_vld & (N_REQ'(1) << lock_id_r));

`ifdef RISCBOY_PPU_BUSARB_ROUND_ROBIN_EN
    logic [W_ID-1:0] last_r;

    assign arb_id_s = pick_first(cand_s, next_id(last_r));

    // Remember the most recently accepted requester for rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= '0;
        end else if (push_s) begin
            last_r <= gnt_id_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign arb_id_s = pick_first(cand_s, W_ID'(PPU_REQ_PIXEL));
`endif

    // Grant selection: a live lock overrides arbitration.
    always_comb begin
        gnt_id_s  = arb_id_s;
        gnt_vld_s = |cand_s;
        if (hold_active_s) begin
            gnt_id_s  = lock_id_r;
            gnt_vld_s = |(cand_s & (N_REQ'(1) << lock_id_r));
        end else begin
            gnt_id_s  = arb_id_s;
            gnt_vld_s = |cand_s;
        end
    end

    // Address mux for the granted requester.
    always_comb begin
        gnt_addr_s = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_id_s == W_ID'(i)) begin
                gnt_addr_s = ppu.req_addr[i*W_ADDR +: W_ADDR];
            end else begin
                gnt_addr_s = gnt_addr_s;
            end
        end
    end

    // Lock next-state: hold the grant while its address phase is stalled,
    // and keep holding while the queue is full and the owner still waits.
    always_comb begin
        state_s   = state_r;
        lock_id_s = lock_id_r;
        case (state_r)
            LOCK_IDLE: begin
                if (gnt_vld_s && !ppu.bus_addr_rdy) begin
                    state_s   = LOCK_HOLD;
                    lock_id_s = gnt_id_s;
                end else begin
                    state_s   = LOCK_IDLE;
                end
            end
            LOCK_HOLD: begin
                if (gnt_vld_s && !ppu.bus_addr_rdy) begin
                    state_s   = LOCK_HOLD;
                    lock_id_s = gnt_id_s;
                end else if (hold_active_s && !gnt_vld_s) begin
                    state_s   = LOCK_HOLD;
                end else begin
                    state_s   = LOCK_IDLE;
                end
            end
            default: begin
                state_s   = LOCK_IDLE;
                lock_id_s = '0;
            end
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= LOCK_IDLE;
            lock_id_r <= '0;
        end else begin
            state_r   <= state_s;
            lock_id_r <= lock_id_s;
        end
    end

    assign push_s = gnt_vld_s & ppu.bus_addr_rdy;
    assign pop_s  = ppu.bus_data_vld & ~q_empty_s;

    sync_fifo #(
        .DEPTH   (MAX_INFLIGHT),
        .WIDTH   (W_ID),
        .W_LEVEL (W_LEVEL)
    ) u_id_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (push_s),
        .wdata (gnt_id_s),
        .pop   (pop_s),
        .rdata (head_id_s),
        .full  (q_full_s),
        .empty (q_empty_s),
        .level (level_s)
    );

    // Sticky flag for a data beat with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan_r <= 1'b0;
        end else if (ppu.bus_data_vld && q_empty_s) begin
            err_orphan_r <= 1'b1;
        end else begin
            err_orphan_r <= err_orphan_r;
        end
    end

    assign ppu.bus_addr_vld    = gnt_vld_s;
    assign ppu.bus_addr        = gnt_addr_s;
    assign ppu.req_rdy         = (N_REQ'(1) << gnt_id_s) & {N_REQ{push_s}};
    assign ppu.req_data_vld    = pop_s ? (N_REQ'(1) << head_id_s) : '0;
    assign ppu.req_data        = ppu.bus_data;
    assign ppu.inflight_level  = level_s;
    assign ppu.err_orphan_data = err_orphan_r;
endmodule

// File: tb/tb_riscboy_ppu_busarb.sv
// Bench for riscboy_ppu_busarb: directed vector table, hand sequences for
// reset and contention, then random traffic against a queue-based model.
module tb_riscboy_ppu_busarb;
    import riscboy_ppu_busarb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    riscboy_ppu_busarb_if bif();
    riscboy_ppu_busarb dut (.clk(clk), .rst_n(rst_n), .ppu(bif));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int mq[$];
    bit m_locked;
    int m_lock;
    int m_last;
    bit m_err;

    typedef struct {
        logic [2:0]  vld;
        logic [17:0] a0, a1, a2;
        logic        rdy, dvld;
        logic [15:0] d;
        logic [2:0]  e_rdy;
        logic        e_bva;
        logic [17:0] e_ba;
        logic [2:0]  e_dv;
        logic [2:0]  e_lvl;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] vld, input logic [17:0] a0, a1, a2,
                                input logic rdy, dvld, input logic [15:0] d,
                                input logic [2:0] e_rdy, input logic e_bva, input logic [17:0] e_ba,
                                input logic [2:0] e_dv, input logic [2:0] e_lvl, input logic e_err);
        vec_t v;
        v.vld = vld; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.rdy = rdy; v.dvld = dvld; v.d = d;
        v.e_rdy = e_rdy; v.e_bva = e_bva; v.e_ba = e_ba; v.e_dv = e_dv; v.e_lvl = e_lvl; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic bit_at(input logic [2:0] v, input int i);
        logic [2:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int m_pick(input logic [2:0] cand);
        int n;
        n = int'(N_REQ);
`ifdef RISCBOY_PPU_BUSARB_ROUND_ROBIN_EN
        for (int k = 1; k <= n; k++) begin
            int idx;
            idx = (m_last + k) % n;
            if (bit_at(cand, idx)) return idx;
        end
`else
        for (int i = 0; i < n; i++) begin
            if (bit_at(cand, i)) return i;
        end
`endif
        return 0;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_locked = 1'b0;
        m_lock   = 0;
        m_last   = 0;
        m_err    = 1'b0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance the model.
    task automatic step(input logic [2:0] vld, input logic [17:0] a0, a1, a2,
                        input logic rdy, input logic dvld, input logic [15:0] d);
        int lvl, gid;
        logic [2:0] cand, e_rdy, e_dv;
        logic [17:0] e_addr;
        logic gv;
        @(negedge clk);
        bif.req_vld      = vld;
        bif.req_addr     = {a2, a1, a0};
        bif.bus_addr_rdy = rdy;
        bif.bus_data_vld = dvld;
        bif.bus_data     = d;
        #1;
        lvl  = mq.size();
        cand = (lvl >= int'(MAX_INFLIGHT)) ? 3'b000 : vld;
        if (m_locked && bit_at(vld, m_lock)) begin
            gid = m_lock;
            gv  = bit_at(cand, m_lock);
        end else begin
            gid = m_pick(cand);
            gv  = (cand != 3'b000);
        end
        e_addr = (gid == 0) ? a0 : ((gid == 1) ? a1 : a2);
        e_rdy  = (gv && rdy) ? (3'b001 << gid) : 3'b000;
        e_dv   = (dvld && lvl > 0) ? (3'b001 << mq[0]) : 3'b000;
        chk("bus_addr_vld", 32'(bif.bus_addr_vld), 32'(gv));
        chk("req_rdy", 32'(bif.req_rdy), 32'(e_rdy));
        if (gv) chk("bus_addr", 32'(bif.bus_addr), 32'(e_addr));
        chk("req_data_vld", 32'(bif.req_data_vld), 32'(e_dv));
        chk("req_data", 32'(bif.req_data), 32'(d));
        chk("inflight_level", 32'(bif.inflight_level), 32'(lvl));
        chk("err_orphan_data", 32'(bif.err_orphan_data), 32'(m_err));
        if (dvld) begin
            if (lvl == 0) m_err = 1'b1;
            else void'(mq.pop_front());
        end
        if (gv && rdy) begin
            mq.push_back(gid);
            m_last = gid;
        end
        if (gv && !rdy) begin
            m_locked = 1'b1;
            m_lock   = gid;
        end else if (m_locked && bit_at(vld, m_lock) && !gv) begin
            m_locked = 1'b1;
        end else begin
            m_locked = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"}, 32'(bif.req_rdy), 32'd0);
        chk({tag, "_bus_addr_vld"}, 32'(bif.bus_addr_vld), 32'd0);
        chk({tag, "_req_data_vld"}, 32'(bif.req_data_vld), 32'd0);
        chk({tag, "_level"}, 32'(bif.inflight_level), 32'd0);
        chk({tag, "_err"}, 32'(bif.err_orphan_data), 32'd0);
    endtask

    logic [2:0] exp_cont [4];

    initial begin
        // vld, a0, a1, a2, rdy, dvld, d | e_rdy, e_bva, e_ba, e_dv, e_lvl, e_err
        // single-requester stream, data two cycles behind
        tbl.push_back(mk(3'b001, 18'h100, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h100, 3'b000, 3'd0, 1'b0));
        tbl.push_back(mk(3'b001, 18'h101, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h101, 3'b000, 3'd1, 1'b0));
        tbl.push_back(mk(3'b001, 18'h102, 18'h0, 18'h0, 1'b1, 1'b1, 16'hA000, 3'b001, 1'b1, 18'h102, 3'b001, 3'd2, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'hA001, 3'b000, 1'b0, 18'h0,   3'b001, 3'd2, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'hA002, 3'b000, 1'b0, 18'h0,   3'b001, 3'd1, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b000, 1'b0, 18'h0,   3'b000, 3'd0, 1'b0));
        // mixed return routing 0, 2, 1 then an orphan beat
        tbl.push_back(mk(3'b001, 18'h200, 18'h0,   18'h0,   1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h200, 3'b000, 3'd0, 1'b0));
        tbl.push_back(mk(3'b100, 18'h0,   18'h0,   18'h222, 1'b1, 1'b0, 16'h0,    3'b100, 1'b1, 18'h222, 3'b000, 3'd1, 1'b0));
        tbl.push_back(mk(3'b010, 18'h0,   18'h111, 18'h0,   1'b1, 1'b0, 16'h0,    3'b010, 1'b1, 18'h111, 3'b000, 3'd2, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0,   18'h0,   1'b1, 1'b1, 16'hD000, 3'b000, 1'b0, 18'h0,   3'b001, 3'd3, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0,   18'h0,   1'b1, 1'b1, 16'hD001, 3'b000, 1'b0, 18'h0,   3'b100, 3'd2, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0,   18'h0,   1'b1, 1'b1, 16'hD002, 3'b000, 1'b0, 18'h0,   3'b010, 3'd1, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0,   18'h0,   1'b1, 1'b1, 16'h0BAD, 3'b000, 1'b0, 18'h0,   3'b000, 3'd0, 1'b0));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0,   18'h0,   1'b1, 1'b0, 16'h0,    3'b000, 1'b0, 18'h0,   3'b000, 3'd0, 1'b1));
        // queue full: no grant while full, regrant only the cycle after a pop
        tbl.push_back(mk(3'b001, 18'h300, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h300, 3'b000, 3'd0, 1'b1));
        tbl.push_back(mk(3'b001, 18'h301, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h301, 3'b000, 3'd1, 1'b1));
        tbl.push_back(mk(3'b001, 18'h302, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h302, 3'b000, 3'd2, 1'b1));
        tbl.push_back(mk(3'b001, 18'h303, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h303, 3'b000, 3'd3, 1'b1));
        tbl.push_back(mk(3'b001, 18'h304, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b000, 1'b0, 18'h0,   3'b000, 3'd4, 1'b1));
        tbl.push_back(mk(3'b001, 18'h304, 18'h0, 18'h0, 1'b1, 1'b1, 16'h0E00, 3'b000, 1'b0, 18'h0,   3'b001, 3'd4, 1'b1));
        tbl.push_back(mk(3'b001, 18'h304, 18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b001, 1'b1, 18'h304, 3'b000, 3'd3, 1'b1));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'h0E01, 3'b000, 1'b0, 18'h0,   3'b001, 3'd4, 1'b1));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'h0E02, 3'b000, 1'b0, 18'h0,   3'b001, 3'd3, 1'b1));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'h0E03, 3'b000, 1'b0, 18'h0,   3'b001, 3'd2, 1'b1));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b1, 16'h0E04, 3'b000, 1'b0, 18'h0,   3'b001, 3'd1, 1'b1));
        tbl.push_back(mk(3'b000, 18'h0,   18'h0, 18'h0, 1'b1, 1'b0, 16'h0,    3'b000, 1'b0, 18'h0,   3'b000, 3'd0, 1'b1));
        // stall lock on req 2, req 0 arrives mid-stall; then a withdrawal
        tbl.push_back(mk(3'b100, 18'h0AA, 18'h0, 18'h2AA, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1, 18'h2AA, 3'b000, 3'd0, 1'b1));
        tbl.push_back(mk(3'b101, 18'h0AA, 18'h0, 18'h2AA, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1, 18'h2AA, 3'b000, 3'd0, 1'b1));
        tbl.push_back(mk(3'b101, 18'h0AA, 18'h0, 18'h2AA, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1, 18'h2AA, 3'b000, 3'd0, 1'b1));
        tbl.push_back(mk(3'b101, 18'h0AA, 18'h0, 18'h2AA, 1'b1, 1'b0, 16'h0, 3'b100, 1'b1, 18'h2AA, 3'b000, 3'd0, 1'b1));
        tbl.push_back(mk(3'b101, 18'h0AA, 18'h0, 18'h2AA, 1'b1, 1'b0, 16'h0, 3'b001, 1'b1, 18'h0AA, 3'b000, 3'd1, 1'b1));
        tbl.push_back(mk(3'b100, 18'h0AA, 18'h0, 18'h2AA, 1'b0, 1'b0, 16'h0, 3'b000, 1'b1, 18'h2AA, 3'b000, 3'd2, 1'b1));
        tbl.push_back(mk(3'b001, 18'h0AA, 18'h0, 18'h2AA, 1'b1, 1'b0, 16'h0, 3'b001, 1'b1, 18'h0AA, 3'b000, 3'd2, 1'b1));

`ifdef RISCBOY_PPU_BUSARB_ROUND_ROBIN_EN
        exp_cont = '{3'b010, 3'b100, 3'b010, 3'b100};
`else
        exp_cont = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif

        // reset state
        rst_n = 1'b0;
        bif.req_vld = 3'b000; bif.req_addr = '0; bif.bus_addr_rdy = 1'b0;
        bif.bus_data_vld = 1'b0; bif.bus_data = 16'h0;
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed table
        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].rdy, tbl[i].dvld, tbl[i].d);
            chk("tbl_req_rdy", 32'(bif.req_rdy), 32'(tbl[i].e_rdy));
            chk("tbl_bus_addr_vld", 32'(bif.bus_addr_vld), 32'(tbl[i].e_bva));
            if (tbl[i].e_bva) chk("tbl_bus_addr", 32'(bif.bus_addr), 32'(tbl[i].e_ba));
            chk("tbl_req_data_vld", 32'(bif.req_data_vld), 32'(tbl[i].e_dv));
            chk("tbl_req_data", 32'(bif.req_data), 32'(tbl[i].d));
            chk("tbl_level", 32'(bif.inflight_level), 32'(tbl[i].e_lvl));
            chk("tbl_err", 32'(bif.err_orphan_data), 32'(tbl[i].e_err));
        end

        // reset with three fetches outstanding
        @(negedge clk);
        bif.req_vld = 3'b000; bif.bus_addr_rdy = 1'b0; bif.bus_data_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(3'b000, 18'h0, 18'h0, 18'h0, 1'b1, 1'b1, 16'h5A5A);
        chk("stale_beat_route", 32'(bif.req_data_vld), 32'd0);

        // contention between requesters 1 and 2
        for (int k = 0; k < 4; k++) begin
            step(3'b110, 18'h0, 18'h111, 18'h222, 1'b1, 1'b0, 16'h0);
            chk("contention_grant", 32'(bif.req_rdy), 32'(exp_cont[k]));
        end
        for (int k = 0; k < 4; k++) begin
            step(3'b000, 18'h0, 18'h0, 18'h0, 1'b1, 1'b1, 16'(k + 32'h1230));
            chk("contention_route", 32'(bif.req_data_vld), 32'(exp_cont[k]));
        end

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(3'($urandom_range(0, 7)), 18'($urandom), 18'($urandom), 18'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscboy_ppu_busarb.md
Name: riscboy_ppu_busarb

Overview:
- Shares the PPU's single halfword memory port between several address-phase requesters: pixel AGU, tilemap fetch and command-list fetch.
- The memory port has split address and data phases, and read data returns in order.
- The block arbitrates address phases and records the requester ID of every issued fetch in an in-order queue. It then routes each returning data beat to its owner.
- It sits between the PPU requesters and the PPU bus master interface.

Parameters:
- N_REQ, 3, number of requesters; index 0 = pixel AGU.
- W_ADDR, 18, halfword address width.
- W_DATA, 16, read data width.
- MAX_INFLIGHT, 4, maximum outstanding fetches; depth of the ID queue.
- W_ID, 2, width of a requester ID; must satisfy 2**W_ID >= N_REQ.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  N_REQ  per-requester address valid
- req_rdy  out  N_REQ  per-requester address accepted
- req_addr  in  N_REQ*W_ADDR  packed addresses; requester i at bits [i*W_ADDR +: W_ADDR]
- req_data_vld  out  N_REQ  one-hot; data beat belongs to requester i
- req_data  out  W_DATA  bus_data broadcast to all requesters
- bus_addr_vld  out  1  downstream address valid
- bus_addr_rdy  in  1  downstream address accepted
- bus_addr  out  W_ADDR  downstream address
- bus_data_vld  in  1  downstream read data valid
- bus_data  in  W_DATA  downstream read data
- inflight_level  out  W_ID+1  current ID queue occupancy
- err_orphan_data  out  1  sticky: data beat arrived with no fetch outstanding

Behaviour:
Reset values:
- All outputs 0, lock state IDLE, ID queue empty, err_orphan_data 0.
- rst_n asserted mid-operation discards all in-flight IDs; no data is routed after reset.

Grant:
- Combinational, zero cycles of latency.
- Candidates are req_vld & ~{N_REQ{full}}, where full = (level == MAX_INFLIGHT).
- full is evaluated before any same-cycle pop: no push while full, even if a pop occurs in that cycle.
- Priority: fixed by default (lowest index wins); see Optional Feature.

Outputs:
- bus_addr_vld = |candidates.
- bus_addr = req_addr of the granted requester.
- req_rdy[g] = bus_addr_rdy & bus_addr_vld for granted g only; 0 for all others.

Lock FSM (two states):
- IDLE -> HOLD when bus_addr_vld && !bus_addr_rdy; lock_id <= granted index.
- While in HOLD, grant is forced to lock_id, so the address does not switch under a stalled handshake.
- HOLD -> IDLE when the lock_id handshake completes.
- HOLD -> IDLE when req_vld[lock_id] drops (requester withdrawal, which the bus tolerates). Arbitration resumes in the same cycle.
- When full is asserted in HOLD, bus_addr_vld drops and the state stays HOLD.

ID queue:
- Push: granted ID on bus_addr_vld && bus_addr_rdy.
- Pop: on bus_data_vld && !empty.
- Simultaneous push and pop are allowed when not full; the level is unchanged.

Data routing:
- req_data_vld = bus_data_vld ? (1 << head_id) : 0.
- Routing is combinational in the same cycle as bus_data_vld.
- req_data = bus_data.
- bus_data_vld while empty: nothing is routed and err_orphan_data is set; it is cleared only by reset.

inflight_level equals the queue occupancy, range 0..MAX_INFLIGHT.

Optional Feature:
- Macro: RISCBOY_PPU_BUSARB_ROUND_ROBIN_EN.
- Defined: rotating priority. A register `last` (reset 0) is updated on each accepted handshake. The highest priority goes to the first candidate above `last`, with wrap-around. The HOLD lock still overrides rotation.
- Undefined: fixed priority, index 0 highest, and the `last` register is absent.

Decomposition:
- Shared constants go in riscboy_ppu_const.vh: requester index localparams (PPU_REQ_PIXEL=0, PPU_REQ_TILE=1, PPU_REQ_CMD=2).
- The ID queue reuses the existing sync_fifo, DEPTH=MAX_INFLIGHT, WIDTH=W_ID, flush tied to 0.
- No other sub-modules.

Test Plan:
- Single-requester stream: req 0 streams 0x100, 0x101, 0x102 with bus_addr_rdy=1 and data returned 2 cycles later. Expect req_rdy[0] each cycle and req_data_vld=3'b001 for three beats in order.
- Contention, fixed priority: req_vld=3'b110. Expect grant to index 1 only while it is held high. With round-robin compiled in: grants alternate 1, 2, 1, 2.
- Stall lock: req 2 is granted while bus_addr_rdy=0 for 3 cycles, and req 0 asserts in cycle 1. Expect bus_addr unchanged (req 2's address) until accept, then req 0 granted.
- Queue full: 4 fetches accepted with no data returned. Expect bus_addr_vld=0 and inflight_level=4. After one data beat (pop), expect a new grant the following cycle, never in the same cycle.
- Mixed return routing: issue order IDs 0, 2, 1 with data D0, D1, D2. Expect req_data_vld = 001, 100, 010 with matching req_data. Then inject bus_data_vld with the queue empty: expect err_orphan_data=1 and no req_data_vld.
- Reset mid-operation: assert rst_n with 3 fetches in flight. Expect level 0, all outputs 0, and no routing of stale beats.
